// File: rtl/hazard_fwd_pkg.sv
// Shared constants for the ID-stage hazard/forwarding unit:
// ISA opcodes, forwarding select encoding and FSM states.
package hazard_fwd_pkg;

  localparam int ISIZE     = 16;
  localparam int RSIZE_DEF = 4;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_ANDI = 4'd5;
  localparam logic [3:0] OP_ORI  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_LW   = 4'd8;
  localparam logic [3:0] OP_SW   = 4'd9;
  localparam logic [3:0] OP_LUI  = 4'd10;
  localparam logic [3:0] OP_LI   = 4'd11;
  localparam logic [3:0] OP_B    = 4'd12;
  localparam logic [3:0] OP_JAL  = 4'd13;
  localparam logic [3:0] OP_JR   = 4'd14;
  localparam logic [3:0] OP_EXEC = 4'd15;

  localparam logic [2:0] FWD_RF = 3'd0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination shift register with a nearest-match
// priority encoder for two source addresses.
module hazard_scoreboard
  import hazard_fwd_pkg::*;
#(
  parameter int RSIZE = RSIZE_DEF,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  input  logic [RSIZE-1:0] inDest,
  input  logic             inLoad,
  input  logic [RSIZE-1:0] src1,
  input  logic [RSIZE-1:0] src2,
  output logic [2:0]       hit1Stage,
  output logic             hit1Load,
  output logic [2:0]       hit2Stage,
  output logic             hit2Load,
  output logic             headValid
);

  logic [DEPTH:1]   vld;
  logic [DEPTH:1]   ld;
  logic [RSIZE-1:0] dst [DEPTH:1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      ld  <= '0;
      for (int k = 1; k <= DEPTH; k++)
        dst[k] <= '0;
    end else begin
      vld[1] <= inValid;
      ld[1]  <= inLoad & inValid;
      dst[1] <= inDest;
      for (int k = 2; k <= DEPTH; k++) begin
        vld[k] <= vld[k-1];
        ld[k]  <= ld[k-1];
        dst[k] <= dst[k-1];
      end
    end
  end

  // Scan oldest to youngest so the nearest match wins.
  always_comb begin
    hit1Stage = FWD_RF;
    hit1Load  = 1'b0;
    hit2Stage = FWD_RF;
    hit2Load  = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (vld[k] && src1 != '0 && dst[k] == src1) begin
        hit1Stage = 3'(k);
        hit1Load  = ld[k];
      end
      if (vld[k] && src2 != '0 && dst[k] == src2) begin
        hit2Stage = 3'(k);
        hit2Load  = ld[k];
      end
    end
  end

  assign headValid = vld[1];

endmodule

// File: rtl/hazard_fwd_unit.sv
// ID-stage forwarding selects, load-use stall and branch flush.
// Optional HAZARD_PERF_CNT_EN adds stall/flush cycle counters.
module hazard_fwd_unit
  import hazard_fwd_pkg::*;
#(
  parameter int RSIZE      = RSIZE_DEF,
  parameter int DEPTH      = 2,
  parameter int LOAD_LAT   = 1,
  parameter int BR_PENALTY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_opcode,
  input  logic [RSIZE-1:0] id_rs,
  input  logic [RSIZE-1:0] id_rt,
  input  logic [RSIZE-1:0] id_rd,
  input  logic             br_taken,
  output logic [2:0]       fwd_src1,
  output logic [2:0]       fwd_src2,
  output logic             stall,
  output logic             flush,
  output logic             ex_valid
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]      stall_cycles,
  output logic [15:0]      flush_cycles
`endif
);

  if (DEPTH < 1 || DEPTH > 6) begin : gBadDepth
    $error("hazard_fwd_unit: DEPTH must be 1..6");
  end
  if (BR_PENALTY < 1 || BR_PENALTY > 7) begin : gBadPen
    $error("hazard_fwd_unit: BR_PENALTY must be 1..7");
  end

  logic [RSIZE-1:0] src1, src2, dest;
  logic             isLoad, useRt, useRd;

  always_comb begin
    src1   = (id_opcode <= OP_SW) ? id_rs : '0;
    useRt  = id_opcode <= OP_OR;
    useRd  = id_opcode inside {OP_SW, OP_LUI, OP_JR, OP_EXEC};
    unique case (1'b1)
      useRt:   src2 = id_rt;
      useRd:   src2 = id_rd;
      default: src2 = '0;
    endcase
    dest = (id_opcode <= OP_LW ||
            id_opcode inside {OP_LUI, OP_LI, OP_JAL})
           ? id_rd : '0;
    isLoad = id_opcode == OP_LW;
  end

  logic [2:0] hit1Stage, hit2Stage;
  logic       hit1Load, hit2Load, headValid;
  logic       haz1, haz2, issue;

  hazard_scoreboard #(
    .RSIZE(RSIZE),
    .DEPTH(DEPTH)
  ) uSb (
    .clk      (clk),
    .rst      (rst),
    .inValid  (issue),
    .inDest   (dest),
    .inLoad   (isLoad),
    .src1     (src1),
    .src2     (src2),
    .hit1Stage(hit1Stage),
    .hit1Load (hit1Load),
    .hit2Stage(hit2Stage),
    .hit2Load (hit2Load),
    .headValid(headValid)
  );

  assign haz1 = hit1Load && hit1Stage != FWD_RF &&
                hit1Stage <= 3'(LOAD_LAT);
  assign haz2 = hit2Load && hit2Stage != FWD_RF &&
                hit2Stage <= 3'(LOAD_LAT);

  assign fwd_src1 = haz1 ? FWD_RF : hit1Stage;
  assign fwd_src2 = haz2 ? FWD_RF : hit2Stage;

  state_t     st, stNext;
  logic [2:0] cnt, cntNext;
  logic       flushRaw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st  <= ST_RUN;
      cnt <= '0;
    end else begin
      st  <= stNext;
      cnt <= cntNext;
    end
  end

  // FLUSH lasts cnt cycles; the br_taken cycle itself is the first.
  always_comb begin
    stNext   = st;
    cntNext  = cnt;
    flushRaw = 1'b0;
    unique case (st)
      ST_RUN: begin
        if (br_taken) begin
          flushRaw = 1'b1;
          if (BR_PENALTY > 1) begin
            stNext  = ST_FLUSH;
            cntNext = 3'(BR_PENALTY - 1);
          end
        end
      end
      ST_FLUSH: begin
        flushRaw = 1'b1;
        if (br_taken) begin
          cntNext = 3'(BR_PENALTY - 1);
        end else if (cnt <= 3'd1) begin
          stNext  = ST_RUN;
          cntNext = '0;
        end else begin
          cntNext = cnt - 3'd1;
        end
      end
      default: stNext = ST_RUN;
    endcase
  end

  assign flush    = rst & flushRaw;
  assign stall    = id_valid & (haz1 | haz2) & ~flush;
  assign issue    = id_valid & ~stall & ~flush;
  assign ex_valid = headValid;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (stall && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (flush && flush_cycles != 16'hFFFF)
        flush_cycles <= flush_cycles + 16'd1;
    end
  end
`endif

endmodule
